// File: rtl/einstein_pkg.sv
// Shared constants for the Einstein interrupt sources: source indices and
// the fixed mode-2 vectors of the non-CTC requesters.
package einstein_pkg;

    localparam int SRC_KB   = 0;
    localparam int SRC_CTC  = 1;
    localparam int SRC_ADC  = 2;
    localparam int SRC_FIRE = 3;

    localparam logic [7:0] VEC_KB   = 8'h0E;
    localparam logic [7:0] VEC_ADC  = 8'h0A;
    localparam logic [7:0] VEC_FIRE = 8'h0C;
    localparam logic [7:0] VEC_NONE = 8'hFF;

    // One-hot decode of a source index; used for pending/in-service updates.
    function automatic logic [3:0] src_onehot(input logic [1:0] idx);
        src_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/einstein_prio_enc.sv
// Lowest-index priority encoder: valid is set when any request bit is set,
// and idx names the lowest set bit.
module einstein_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/einstein_int_ctrl.sv
// Mode-2 interrupt controller for the Einstein Z80: per-source pending and
// in-service tracking, daisy-chain style priority, vector supply and RETI retire.
module einstein_int_ctrl
    import einstein_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IW    = $clog2(N_SRC)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [N_SRC-1:0]   req,
    input  logic [N_SRC-1:0]   clr,
    input  logic               mask_we,
    input  logic [IW-1:0]      mask_idx,
    input  logic               mask_d,
    input  logic [8*N_SRC-1:0] vec_in,
    input  logic               inta,
    input  logic               reti,
    output logic               int_n,
    output logic [7:0]         vec_out,
    output logic [N_SRC-1:0]   ack,
    output logic [N_SRC-1:0]   pending,
    output logic [N_SRC-1:0]   in_service
);

    // Handshake: inta is a multi-cycle level from the CPU. Only its first
    // cycle (inta & ~inta_d) acknowledges; ack pulses one cycle later for
    // exactly one cycle, and vec_out holds steady for the whole of inta.

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] req_d;
    logic             inta_d;

    logic [N_SRC-1:0] elig;
    logic             win_valid;
    logic [IW-1:0]    win_idx;
    logic             reti_valid;
    logic [IW-1:0]    reti_idx;

    logic             inta_first;
    logic             ack_now;
    logic [N_SRC-1:0] win_onehot;
    logic [N_SRC-1:0] reti_onehot;
    logic [N_SRC-1:0] mask_onehot;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_drop;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] ins_next;

    // An in-service source blocks itself and everything below it (IEI/IEO).
    always_comb begin
        logic blk;
        blk  = 1'b0;
        elig = '0;
        for (int k = 0; k < N_SRC; k++) begin
            blk     = blk | in_service[k];
            elig[k] = pending[k] & ~blk;
        end
    end

    einstein_prio_enc #(.N(N_SRC), .W(IW)) u_win_enc (
        .req   (elig),
        .valid (win_valid),
        .idx   (win_idx)
    );

    einstein_prio_enc #(.N(N_SRC), .W(IW)) u_reti_enc (
        .req   (in_service),
        .valid (reti_valid),
        .idx   (reti_idx)
    );

    always_comb begin
        inta_first  = inta & ~inta_d;
        ack_now     = inta_first & win_valid;
        win_onehot  = N_SRC'(1) << win_idx;
        reti_onehot = N_SRC'(1) << reti_idx;
        mask_onehot = N_SRC'(1) << mask_idx;

        pend_set  = req & ~req_d & ~mask;
        pend_drop = clr;
        if (ack_now)
            pend_drop = pend_drop | win_onehot;
        if (mask_we && mask_d)
            pend_drop = pend_drop | mask_onehot;
        // A fresh edge outranks any drop arriving in the same cycle.
        pend_next = (pending & ~pend_drop) | pend_set;

        ins_next = in_service;
        if (reti && reti_valid)
            ins_next = ins_next & ~reti_onehot;
        if (ack_now)
            ins_next = ins_next | win_onehot;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mask       <= '1;
            pending    <= '0;
            in_service <= '0;
            req_d      <= req;
            int_n      <= 1'b1;
            vec_out    <= VEC_NONE;
            ack        <= '0;
            inta_d     <= 1'b0;
        end else begin
            if (mask_we)
                mask[mask_idx] <= mask_d;
            pending    <= pend_next;
            in_service <= ins_next;
            req_d      <= req;
            inta_d     <= inta;
            int_n      <= ~win_valid;
            ack        <= ack_now ? win_onehot : '0;
            if (!inta)
                vec_out <= win_valid ? vec_in[win_idx*8 +: 8] : VEC_NONE;
        end
    end

endmodule

// File: doc/einstein_int_ctrl.md
Name: einstein_int_ctrl

Overview:
- Mode-2 interrupt controller and arbiter for the Einstein Z80 core.
- Replaces the ad-hoc per-source interrupt flops and vector mux with one prioritised daisy-chain emulation.
- Sources: keyboard, CTC, ADC, fire button. The block tracks per-source pending and in-service state, drives the CPU INT_n line, supplies the vector during INTA, and retires service on RETI.
- Sits between the source blocks, the CPU data-bus mux and the z80reti decoder.

Parameters:
- N_SRC, 4, number of requesters; index 0 has highest priority.
- IW, 2, index width, equal to $clog2(N_SRC).

Ports:
- clk_sys  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_SRC  request levels, synchronous to clk_sys; a rising edge raises a request.
- clr  in  N_SRC  1-cycle strobes; drop the pending request (e.g. status-port read).
- mask_we  in  1  mask write strobe.
- mask_idx  in  IW  source selected by a mask write.
- mask_d  in  1  mask value; 1 = masked.
- vec_in  in  8*N_SRC  per-source vector; byte k belongs to source k.
- inta  in  1  INTA cycle level (~m1_n & ~iorq_n), held over several clk_sys cycles.
- reti  in  1  1-cycle RETI strobe.
- int_n  out  1  to CPU INT_n, registered.
- vec_out  out  8  vector for the data-bus mux, registered.
- ack  out  N_SRC  one-hot 1-cycle pulse to the source whose interrupt was acknowledged.
- pending  out  N_SRC  pending flags.
- in_service  out  N_SRC  in-service flags.

Behaviour:
- Reset (synchronous):
  - mask = all 1s; pending = 0; in_service = 0.
  - req_d (edge-detect history) = current req.
  - int_n = 1; vec_out = 8'hFF; ack = 0; inta_d = 0.
- Per-source pending:
  - Set on a rising edge of req[k] (req[k] & ~req_d[k]) while mask[k] = 0.
  - Cleared by clr[k], by acknowledge, or by mask[k] being written to 1.
  - A set and a clr in the same cycle: set wins.
  - Edges arriving while masked are discarded; unmasking does not resurrect them.
- Eligibility: source k is eligible when pending[k] = 1 and no in_service[j] = 1 for any j <= k. This emulates IEI/IEO; an in-service source also blocks itself.
- Winner: the lowest-index eligible source. It is combinational and internal.
- int_n <= ~(any eligible), registered. Latency from req edge to int_n low is 2 cycles: one to set pending, one to register int_n.
- vec_out:
  - While inta = 0: vec_out <= winner's vec_in byte, or 8'hFF if there is no winner. The vector is therefore valid whenever int_n = 0.
  - While inta = 1: vec_out is frozen.
- Acknowledge (inta & ~inta_d, first cycle only):
  - If a winner exists: pending[w] <= 0, in_service[w] <= 1, ack[w] pulses on the next cycle.
  - If there is no winner (spurious INTA): no state change; vec_out stays 8'hFF.
  - Later cycles of the same INTA are ignored.
- RETI: clears the lowest-index set in_service bit. With none set, it is ignored.
- RETI and the INTA first cycle in the same cycle: both apply. The winner is computed from pre-cycle state, and the RETI clear targets the pre-cycle in_service.
- Nesting:
  - A higher-priority request can interrupt an in-service lower one, giving two bits in service.
  - Lower- or equal-priority requests wait until RETI.
- Mask write: it is visible for eligibility on the next cycle. It does not affect in_service.
- Reset mid-INTA or mid-service: everything returns to reset values. A req held high through reset does not count as an edge.

Decomposition:
- Shared package einstein_pkg holds:
  - source index constants SRC_KB=0, SRC_CTC=1, SRC_ADC=2, SRC_FIRE=3;
  - fixed vectors VEC_KB=8'h0E, VEC_ADC=8'h0A, VEC_FIRE=8'h0C;
  - VEC_NONE=8'hFF.
- The CTC byte of vec_in is connected to the CTC's own vector output.
- One sub-module, einstein_prio_enc: a parameterised lowest-index priority encoder (valid + index). It is used for the winner and the RETI target.

Test Plan:
- Reset state: after reset, int_n=1, vec_out=FF, mask=F. Unmask KB then pulse req[0] -> int_n=0 two cycles later, vec_out=0E.
- Acknowledge: hold inta for 4 cycles -> ack=0001 for exactly one cycle, pending[0]=0, in_service[0]=1, int_n=1.
- Nesting order: with FIRE in service, a CTC request with vec_in byte 1 = 8'h20 -> int_n=0, vec_out=20. After its ack, the first reti clears in_service[1] only; the second reti clears in_service[3].
- Blocking: with KB in service, a FIRE request -> int_n stays 1 until reti, then goes 0 with vec_out=0C.
- Masking and clearing:
  - pending ADC, then mask_we idx=2 d=1 -> pending[2]=0, int_n=1.
  - clr[0] in the same cycle as a KB edge -> pending[0]=1.
- Spurious and simultaneous events:
  - inta with nothing pending -> vec_out=FF, no ack.
  - reti with nothing in service -> no change.
  - reset asserted mid-INTA -> all outputs at reset values the next cycle.
